// File: rtl/psum_spad.sv
// Partial-sum scratchpad: write / in-place accumulate with hazard forwarding,
// sequential clear engine (busy), optional saturation, sticky overflow.
module psum_spad #(
  parameter int D_WIDTH    = 32,
  parameter int DEPTH      = 256,
  parameter int A_WIDTH    = $clog2(DEPTH),
  parameter bit CLR_ON_RST = 1'b1,
  parameter bit SATURATE   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr_req,
  output logic               o_busy,
  input  logic               i_wen,
  input  logic               i_acc_en,
  input  logic [A_WIDTH-1:0] i_w_addr,
  input  logic [D_WIDTH-1:0] i_w_data,
  input  logic               i_ren,
  input  logic [A_WIDTH-1:0] i_r_addr,
  output logic [D_WIDTH-1:0] o_r_data,
  output logic               o_r_valid,
  output logic               o_ovf
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [A_WIDTH:0]   LP_DEPTH = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] LP_LAST  = A_WIDTH'(DEPTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [A_WIDTH-1:0]   r_cnt;
  logic [D_WIDTH-1:0]   r_mem [DEPTH];

  logic                 r_p_vld;
  logic                 r_p_acc;
  logic [A_WIDTH-1:0]   r_p_addr;
  logic [D_WIDTH-1:0]   r_p_data;
  logic [D_WIDTH-1:0]   r_p_old;

  logic [D_WIDTH-1:0]   r_r_data;
  logic                 r_r_valid;
  logic                 r_ovf;

  logic                 w_idle;
  logic                 w_clr_go;
  logic                 w_accept;
  logic                 w_w_in;
  logic                 w_r_in;
  logic                 w_wr_go;
  logic                 w_rd_go;
  logic [D_WIDTH:0]     w_sum;
  logic                 w_carry;
  logic [D_WIDTH-1:0]   w_p_result;
  logic                 w_w_fwd;
  logic                 w_r_fwd;
  logic [D_WIDTH-1:0]   w_w_old;
  logic [D_WIDTH-1:0]   w_r_val;

  assign w_idle   = (r_state == S_IDLE);
  assign w_clr_go = w_idle & i_clr_req;
  // A clear request wins over any user op presented in the same cycle.
  assign w_accept = w_idle & ~i_clr_req;

  assign w_w_in  = ({1'b0, i_w_addr} < LP_DEPTH);
  assign w_r_in  = ({1'b0, i_r_addr} < LP_DEPTH);
  assign w_wr_go = w_accept & i_wen & w_w_in;
  assign w_rd_go = w_accept & i_ren;

  // Stage-P result, committed to the array at the next edge.
  assign w_sum      = {1'b0, r_p_old} + {1'b0, r_p_data};
  assign w_carry    = r_p_vld & r_p_acc & w_sum[D_WIDTH];
  assign w_p_result = !r_p_acc ? r_p_data :
                      (SATURATE && w_sum[D_WIDTH]) ? {D_WIDTH{1'b1}} :
                      w_sum[D_WIDTH-1:0];

  // The array lags stage P by one edge, so P's result is the newest value.
  assign w_w_fwd = r_p_vld & (r_p_addr == i_w_addr);
  assign w_r_fwd = r_p_vld & (r_p_addr == i_r_addr);
  assign w_w_old = w_w_fwd ? w_p_result : r_mem[i_w_addr];
  assign w_r_val = !w_r_in ? '0 : (w_r_fwd ? w_p_result : r_mem[i_r_addr]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLR_ON_RST ? S_CLEAR : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        o_busy = 1'b1;
        if (r_cnt == LP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + A_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_vld <= 1'b0;
    end else begin
      r_p_vld <= w_wr_go;
      if (w_wr_go) begin
        r_p_acc  <= i_acc_en;
        r_p_addr <= i_w_addr;
        r_p_data <= i_w_data;
        r_p_old  <= w_w_old;
      end
    end
  end

  // Reset drops the pending stage-P write; the array itself is never reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (r_p_vld) begin
        r_mem[r_p_addr] <= w_p_result;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r_data  <= '0;
      r_r_valid <= 1'b0;
    end else begin
      r_r_valid <= w_rd_go;
      if (w_rd_go) r_r_data <= w_r_val;
    end
  end

  // A carry from the op committing at the clear-acceptance edge still sets ovf.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~w_clr_go) | w_carry;
    end
  end

  assign o_r_data  = r_r_data;
  assign o_r_valid = r_r_valid;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_psum_spad.sv
// Bench for psum_spad: a 256-entry wrapping instance checked by table and a
// random-op model, plus a 12-entry saturating instance for the corner cases.
module tb_psum_spad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_rst, a_clr, a_busy, a_wen, a_acc, a_ren, a_rvalid, a_ovf;
  logic [7:0]  a_wa, a_ra;
  logic [31:0] a_wd, a_rdata;

  logic        b_rst, b_clr, b_busy, b_wen, b_acc, b_ren, b_rvalid, b_ovf;
  logic [3:0]  b_wa, b_ra;
  logic [31:0] b_wd, b_rdata;

  psum_spad #(.D_WIDTH(32), .DEPTH(256), .CLR_ON_RST(1'b1), .SATURATE(1'b0)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_clr_req(a_clr), .o_busy(a_busy),
    .i_wen(a_wen), .i_acc_en(a_acc), .i_w_addr(a_wa), .i_w_data(a_wd),
    .i_ren(a_ren), .i_r_addr(a_ra), .o_r_data(a_rdata), .o_r_valid(a_rvalid),
    .o_ovf(a_ovf)
  );

  psum_spad #(.D_WIDTH(32), .DEPTH(12), .CLR_ON_RST(1'b0), .SATURATE(1'b1)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_clr_req(b_clr), .o_busy(b_busy),
    .i_wen(b_wen), .i_acc_en(b_acc), .i_w_addr(b_wa), .i_w_data(b_wd),
    .i_ren(b_ren), .i_r_addr(b_ra), .o_r_data(b_rdata), .o_r_valid(b_rvalid),
    .o_ovf(b_ovf)
  );

  // Reference model for u_a: every accepted op takes effect immediately,
  // reads see the state before the same-cycle write.
  logic [31:0] m_mem [256];
  logic        m_ovf;
  logic [31:0] m_rdata;

  typedef struct {
    logic        wen;
    logic        acc;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        ren;
    logic [7:0]  ra;
    logic        rv;
    logic [31:0] rd;
    logic        ovf;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic wen, input logic acc, input logic [7:0] wa,
                              input logic [31:0] wd, input logic ren, input logic [7:0] ra,
                              input logic rv, input logic [31:0] rd, input logic ovf);
    vec_t v;
    v.wen = wen; v.acc = acc; v.wa = wa; v.wd = wd; v.ren = ren; v.ra = ra;
    v.rv = rv; v.rd = rd; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_clr = 1'b0; a_wen = 1'b0; a_acc = 1'b0; a_ren = 1'b0;
    a_wa = '0; a_wd = '0; a_ra = '0;
  endtask

  task automatic b_idle();
    b_clr = 1'b0; b_wen = 1'b0; b_acc = 1'b0; b_ren = 1'b0;
    b_wa = '0; b_wd = '0; b_ra = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  task automatic a_cycle(input string tag, input logic wen, input logic acc,
                         input logic [7:0] wa, input logic [31:0] wd,
                         input logic ren, input logic [7:0] ra);
    logic        exp_ovf;
    logic [32:0] s;
    exp_ovf = m_ovf;
    if (ren) m_rdata = m_mem[ra];
    if (wen) begin
      if (acc) begin
        s = {1'b0, m_mem[wa]} + {1'b0, wd};
        if (s[32]) m_ovf = 1'b1;
        m_mem[wa] = s[31:0];
      end else begin
        m_mem[wa] = wd;
      end
    end
    a_wen = wen; a_acc = acc; a_wa = wa; a_wd = wd; a_ren = ren; a_ra = ra;
    tick();
    chk({tag, ".r_valid"}, 32'(a_rvalid), 32'(ren));
    chk({tag, ".r_data"}, a_rdata, m_rdata);
    chk({tag, ".ovf"}, 32'(a_ovf), 32'(exp_ovf));
    a_idle();
  endtask

  task automatic b_cycle(input logic wen, input logic acc, input logic [3:0] wa,
                         input logic [31:0] wd, input logic ren, input logic [3:0] ra);
    b_wen = wen; b_acc = acc; b_wa = wa; b_wd = wd; b_ren = ren; b_ra = ra;
    tick();
    b_idle();
  endtask

  task automatic count_busy(input bit use_b, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((use_b ? b_busy : a_busy) && n < 1000);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    logic wen, acc, ren;
    logic [7:0] wa, ra;
    logic [31:0] wd;

    a_idle(); b_idle();
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    chk("a.rst.busy", 32'(a_busy), 32'd1);
    chk("a.rst.r_valid", 32'(a_rvalid), 32'd0);
    chk("a.rst.r_data", a_rdata, 32'd0);
    chk("a.rst.ovf", 32'(a_ovf), 32'd0);
    chk("b.rst.busy", 32'(b_busy), 32'd0);
    chk("b.rst.r_valid", 32'(b_rvalid), 32'd0);
    chk("b.rst.r_data", b_rdata, 32'd0);
    chk("b.rst.ovf", 32'(b_ovf), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    model_clear(); m_ovf = 1'b0; m_rdata = '0;

    count_busy(1'b0, n);
    chk("a.rst_clear_cycles", n, 32'd256);
    a_cycle("a.post_clr0", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd0);
    a_cycle("a.post_clr255", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd255);
    for (int i = 0; i < 4; i++)
      a_cycle("a.post_clr_rnd", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'($urandom_range(0, 255)));

    //          wen   acc   wa    wd             ren   ra    rv    rd             ovf
    tbl[0]  = mk(1'b1, 1'b0, 8'd5, 32'h10,       1'b0, 8'd0, 1'b0, 32'h0,        1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 8'd5, 1'b1, 32'h10,       1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 8'd3, 32'd1,        1'b0, 8'd0, 1'b0, 32'h10,       1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 8'd3, 32'd2,        1'b0, 8'd0, 1'b0, 32'h10,       1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 8'd3, 32'd3,        1'b1, 8'd3, 1'b1, 32'd3,        1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 8'd3, 32'd4,        1'b0, 8'd0, 1'b0, 32'd3,        1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 8'd3, 1'b1, 32'd10,       1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 8'd9, 32'h01,       1'b0, 8'd0, 1'b0, 32'd10,       1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 8'd9, 32'hAB,       1'b1, 8'd9, 1'b1, 32'h01,       1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 8'd9, 1'b1, 32'hAB,       1'b0);
    tbl[10] = mk(1'b1, 1'b0, 8'd7, 32'hFFFFFFFF, 1'b0, 8'd0, 1'b0, 32'hAB,       1'b0);
    tbl[11] = mk(1'b1, 1'b1, 8'd7, 32'd2,        1'b1, 8'd7, 1'b1, 32'hFFFFFFFF, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 8'd7, 1'b1, 32'h1,        1'b1);
    tbl[13] = mk(1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 8'd0, 1'b0, 32'h1,        1'b1);

    for (int i = 0; i < 14; i++) begin
      a_cycle("a.tbl", tbl[i].wen, tbl[i].acc, tbl[i].wa, tbl[i].wd, tbl[i].ren, tbl[i].ra);
      chk($sformatf("a.tbl[%0d].r_valid", i), 32'(a_rvalid), 32'(tbl[i].rv));
      chk($sformatf("a.tbl[%0d].r_data", i), a_rdata, tbl[i].rd);
      chk($sformatf("a.tbl[%0d].ovf", i), 32'(a_ovf), 32'(tbl[i].ovf));
    end

    for (int i = 0; i < 400; i++) begin
      wen = 1'($urandom_range(0, 1));
      acc = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      wa  = 8'($urandom_range(0, 15));
      ra  = 8'($urandom_range(0, 15));
      wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      a_cycle("a.rnd", wen, acc, wa, wd, ren, ra);
    end

    // Clear accepted while an accumulate is in flight, with wen/ren ignored.
    a_cycle("a.pre_clr_w", 1'b1, 1'b0, 8'd3, 32'h100, 1'b0, 8'd0);
    a_cycle("a.pre_clr_acc", 1'b1, 1'b1, 8'd3, 32'h5, 1'b0, 8'd0);
    a_clr = 1'b1; a_wen = 1'b1; a_wa = 8'd4; a_wd = 32'h77; a_ren = 1'b1; a_ra = 8'd3;
    tick();
    a_idle();
    chk("a.clr.busy", 32'(a_busy), 32'd1);
    chk("a.clr.r_valid", 32'(a_rvalid), 32'd0);
    chk("a.clr.r_data_hold", a_rdata, m_rdata);
    chk("a.clr.ovf_cleared", 32'(a_ovf), 32'd0);
    count_busy(1'b0, n);
    chk("a.clr_cycles", n, 32'd256);
    model_clear(); m_ovf = 1'b0;
    a_cycle("a.after_clr4", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd4);
    a_cycle("a.after_clr3", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd3);

    // Reset in the middle of a clear restarts it from entry 0.
    a_cycle("a.w20", 1'b1, 1'b0, 8'd20, 32'h55, 1'b0, 8'd0);
    a_cycle("a.r20", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd20);
    a_clr = 1'b1;
    tick();
    a_idle();
    repeat (10) tick();
    a_rst = 1'b1;
    tick();
    chk("a.midrst.busy", 32'(a_busy), 32'd1);
    chk("a.midrst.r_data", a_rdata, 32'd0);
    chk("a.midrst.r_valid", 32'(a_rvalid), 32'd0);
    a_rst = 1'b0;
    count_busy(1'b0, n);
    chk("a.midrst_clear_cycles", n, 32'd256);
    model_clear(); m_ovf = 1'b0; m_rdata = '0;
    a_cycle("a.after_midrst", 1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd20);

    // Saturating 12-entry instance.
    b_cycle(1'b1, 1'b0, 4'd7, 32'hFFFFFFFF, 1'b0, 4'd0);
    b_cycle(1'b1, 1'b1, 4'd7, 32'd2, 1'b0, 4'd0);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
    chk("b.sat.r_valid", 32'(b_rvalid), 32'd1);
    chk("b.sat.r_data", b_rdata, 32'hFFFFFFFF);
    chk("b.sat.ovf", 32'(b_ovf), 32'd1);
    b_cycle(1'b1, 1'b0, 4'd13, 32'h99, 1'b0, 4'd0);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd13);
    chk("b.oor.r_valid", 32'(b_rvalid), 32'd1);
    chk("b.oor.r_data", b_rdata, 32'd0);
    chk("b.oor.ovf_sticky", 32'(b_ovf), 32'd1);

    b_cycle(1'b1, 1'b0, 4'd11, 32'h5, 1'b0, 4'd0);
    b_cycle(1'b1, 1'b0, 4'd10, 32'h100, 1'b0, 4'd0);
    b_cycle(1'b1, 1'b1, 4'd10, 32'h20, 1'b0, 4'd0);
    b_clr = 1'b1; b_wen = 1'b1; b_wa = 4'd11; b_wd = 32'h77; b_ren = 1'b1; b_ra = 4'd10;
    tick();
    b_idle();
    chk("b.clr.busy", 32'(b_busy), 32'd1);
    chk("b.clr.r_valid", 32'(b_rvalid), 32'd0);
    chk("b.clr.ovf_cleared", 32'(b_ovf), 32'd0);
    tick(); tick();
    b_rst = 1'b1;
    tick();
    chk("b.midrst.busy", 32'(b_busy), 32'd0);
    b_rst = 1'b0;
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10);
    chk("b.inflight_acc_committed", b_rdata, 32'h120);
    chk("b.inflight.r_valid", 32'(b_rvalid), 32'd1);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd11);
    chk("b.clr_wen_ignored", b_rdata, 32'h5);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
    chk("b.partial_clear_e0", b_rdata, 32'd0);

    b_clr = 1'b1;
    tick();
    b_idle();
    count_busy(1'b1, n);
    chk("b.clr_cycles", n, 32'd12);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10);
    chk("b.full_clear_e10", b_rdata, 32'd0);
    b_cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd11);
    chk("b.full_clear_e11", b_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
